instr_prefetch: RTL and testbench

INSTR_PREFETCH -- requirements
Module: instr_prefetch

---
 rtl/instr_prefetch.sv | 123 ++++++++++++
 tb/tb_instr_prefetch.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch.sv
// rtl/instr_prefetch.sv - in-order instruction prefetch buffer with redirect flush and credit-limited fetch
module instr_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [31:0]   last_pc;
  logic [31:0]   last_instr;
  logic [31:0]   target_pc;
  logic [CW:0]   credit_used;

  logic accept;
  logic rsp;
  logic push;
  logic pop;
  logic fifo_empty;

  assign target_pc   = redirect_pc & 32'hFFFF_FFFC;
  assign credit_used = {1'b0, count} + {1'b0, outstanding};
  assign fifo_empty  = (count == '0);

  // Buffered plus in-flight words never exceed DEPTH, so a response always has a free slot.
  assign imem_req  = !reset && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;

  assign accept = imem_req && imem_ready;
  assign rsp    = imem_rvalid && (outstanding != '0);
  assign push   = rsp && (discard == '0) && !redirect_valid;
  assign pop    = if_valid && if_ready;

  assign if_valid = !reset && !fifo_empty;
  assign if_pc    = fifo_empty ? last_pc    : pc_mem[rd_ptr];
  assign if_instr = fifo_empty ? last_instr : instr_mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[wr_ptr]    <= resp_pc;
      instr_mem[wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      last_pc     <= '0;
      last_instr  <= '0;
    end else begin
      // Keep a copy of the visible head so the outputs hold once the buffer drains.
      if (!fifo_empty) begin
        last_pc    <= pc_mem[rd_ptr];
        last_instr <= instr_mem[rd_ptr];
      end

      if (accept && !rsp) begin
        outstanding <= outstanding + CW'(1);
      end else if (!accept && rsp) begin
        outstanding <= outstanding - CW'(1);
      end

      if (redirect_valid) begin
        fetch_pc <= target_pc;
        resp_pc  <= target_pc;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        // Everything still in flight after this edge belongs to the old stream.
        discard  <= outstanding - CW'(rsp);
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (rsp && (discard != '0)) begin
          discard <= discard - CW'(1);
        end
        if (push) begin
          wr_ptr  <= wr_ptr + AW'(1);
          resp_pc <= resp_pc + 32'd4;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        if (push && !pop) begin
          count <= count + CW'(1);
        end else if (!push && pop) begin
          count <= count - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// tb/tb_instr_prefetch.sv - randomized and directed bench for instr_prefetch against a stream-level model
module tb_instr_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;

  instr_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mreq_t;

  mreq_t       mq[$];
  int          cyc, epoch, last_due, lat, npops, acc_cnt;
  int          pass_cnt, chk_cnt;
  bit          rnd, post_redirect;
  logic [31:0] exp_fetch, exp_head;

  // Memory contents: a bijection of the address so every word is distinct.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {~a[15:0], a[31:16]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // One clock: sample at negedge, advance model and memory, drive next inputs after the edge.
  task automatic step();
    int          live, stale, lat_now, due;
    bit          acc, rv;
    logic [31:0] a;
    @(negedge clock);
    stale = 0;
    foreach (mq[i]) if (mq[i].epoch != epoch) stale++;
    live = int'((exp_fetch - exp_head) >> 2);
    if (reset) begin
      check("reset_req", imem_req, 0);
      check("reset_valid", if_valid, 0);
    end else begin
      check("req", imem_req, !redirect_valid && (live + stale < DEPTH));
      if (imem_req) check("addr", imem_addr, exp_fetch);
      if (post_redirect) check("valid_after_redirect", if_valid, 0);
      if (if_valid && if_ready && !redirect_valid) begin
        check("pop_pc", if_pc, exp_head);
        check("pop_instr", if_instr, word_at(exp_head));
        exp_head += 32'd4;
        npops++;
      end
    end
    acc = imem_req && imem_ready;
    rv  = imem_rvalid;
    a   = imem_addr;
    post_redirect = !reset && redirect_valid;
    if (reset) begin
      exp_fetch = RESET_PC;
      exp_head  = RESET_PC;
      mq.delete();
      last_due = 0;
      epoch++;
    end else begin
      if (rv && mq.size() != 0) void'(mq.pop_front());
      if (acc) begin
        acc_cnt++;
        lat_now = rnd ? int'($urandom_range(4, 1)) : lat;
        due = cyc + lat_now;
        if (due < last_due) due = last_due;
        last_due = due;
        mq.push_back('{a, due, epoch});
        exp_fetch += 32'd4;
      end
      if (redirect_valid) begin
        exp_fetch = redirect_pc & 32'hFFFF_FFFC;
        exp_head  = exp_fetch;
        epoch++;
      end
    end
    @(posedge clock);
    cyc++;
    #1;
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_at(mq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    if (rnd) begin
      imem_ready     = ($urandom_range(99) < 70);
      if_ready       = ($urandom_range(99) < 70);
      redirect_valid = ($urandom_range(99) < 4);
      redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    redirect_valid = 1'b0;
    repeat (n) step();
    reset = 1'b0;
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!if_valid && n < 30) begin
      step();
      #1;
      n++;
    end
    check(tag, if_valid, 1);
  endtask

  initial begin
    int p0, a0;
    pass_cnt = 0; chk_cnt = 0; cyc = 0; epoch = 0; last_due = 0; lat = 1;
    npops = 0; acc_cnt = 0; rnd = 0; post_redirect = 0;
    exp_fetch = RESET_PC; exp_head = RESET_PC;
    reset = 1'b1; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b1;

    // Streaming from reset with 1-cycle memory
    do_reset(3);
    check("t1_first_req", imem_req, 1);
    check("t1_first_addr", imem_addr, RESET_PC);
    check("t1_c0_valid", if_valid, 0);
    step(); #1;
    check("t1_c1_valid", if_valid, 0);
    step(); #1;
    check("t1_c2_valid", if_valid, 1);
    for (int i = 0; i < 4; i++) begin
      check("t1_stream_pc", if_pc, 32'(4 * i));
      step(); #1;
    end
    p0 = npops;
    repeat (20) step();
    check("t1_throughput", npops - p0, 20);

    // Backpressure: buffer fills to DEPTH and then drains in order
    do_reset(2);
    if_ready = 1'b0;
    a0 = acc_cnt;
    repeat (8) step();
    #1;
    check("t2_accepts", acc_cnt - a0, DEPTH);
    check("t2_req_stalled", imem_req, 0);
    check("t2_head_valid", if_valid, 1);
    check("t2_head_pc", if_pc, 32'h0);
    if_ready = 1'b1;
    p0 = npops;
    for (int i = 0; i < 4; i++) begin
      check("t2_drain_pc", if_pc, 32'(4 * i));
      step(); #1;
    end
    check("t2_drain_count", npops - p0, 4);

    // Redirect with two requests in flight on 3-cycle memory
    do_reset(2);
    lat = 3;
    step(); step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    #1;
    check("t3_flushed", if_valid, 0);
    wait_valid("t3_valid");
    check("t3_pc0", if_pc, 32'h100);
    step(); #1;
    check("t3_pc1", if_pc, 32'h104);

    // Redirect coinciding with a response and a pop
    do_reset(2);
    lat = 1;
    repeat (6) step();
    #1;
    check("t4_pre_valid", if_valid, 1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    step();
    redirect_valid = 1'b0;
    #1;
    check("t4_empty", if_valid, 0);
    wait_valid("t4_valid");
    check("t4_pc", if_pc, 32'h200);
    check("t4_instr", if_instr, word_at(32'h200));

    // Fetch address wrap-around
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    #1;
    wait_valid("t5_valid");
    check("t5_pc0", if_pc, 32'hFFFF_FFF8);
    step(); #1;
    check("t5_pc1", if_pc, 32'hFFFF_FFFC);
    step(); #1;
    check("t5_pc2", if_pc, 32'h0000_0000);

    // Reset while the buffer is partly full with a fetch in flight
    do_reset(2);
    lat = 2;
    if_ready = 1'b0;
    repeat (5) step();
    #1;
    check("t6_pre_valid", if_valid, 1);
    reset = 1'b1;
    #1;
    check("t6_reset_valid", if_valid, 0);
    check("t6_reset_req", imem_req, 0);
    step();
    reset = 1'b0;
    #1;
    check("t6_post_valid", if_valid, 0);
    check("t6_post_req", imem_req, 1);
    check("t6_post_addr", imem_addr, RESET_PC);
    if_ready = 1'b1;
    wait_valid("t6_valid");
    check("t6_pc", if_pc, RESET_PC);

    // Randomized traffic: latency, stalls and redirects
    do_reset(2);
    rnd = 1'b1;
    repeat (3000) step();
    rnd = 1'b0;
    imem_ready = 1'b1;
    if_ready = 1'b1;
    redirect_valid = 1'b0;
    p0 = npops;
    repeat (30) step();
    check("rnd_progress", npops > p0, 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
